// File: rtl/booth_chk_pkg.sv
// rtl/booth_chk_pkg.sv - shared types, widths and mod-3 helpers for the Booth residue checker
package booth_chk_pkg;

  localparam int OP_W  = 13;
  localparam int RES_W = 26;

  typedef enum logic [1:0] {IDLE, WAIT_DONE, CHECK, REPORT} chk_state_t;

  // 2^i mod 3 alternates 1,2; the two's-complement sign bit carries the negated weight
  function automatic logic [1:0] mod3_weight(input logic [4:0] index, input logic [4:0] msb_index);
    logic [1:0] w;
    w = index[0] ? 2'd2 : 2'd1;
    if (index == msb_index) w = 2'd3 - w;
    return w;
  endfunction

  function automatic logic [1:0] mod3_mul(input logic [1:0] a, input logic [1:0] b);
    logic [3:0] p;
    p = {2'b00, a} * {2'b00, b};
    return (p == 4'd4) ? 2'd1 : p[1:0];
  endfunction

endpackage

// File: rtl/mod3_serial_acc.sv
// rtl/mod3_serial_acc.sv - bit-serial mod-3 residue accumulator
module mod3_serial_acc (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       clear,
  input  logic       enable,
  input  logic       data_bit,
  input  logic [1:0] weight,
  output logic [1:0] residue
);

  logic [2:0] sum;

  always_comb begin
    sum = {1'b0, residue} + (data_bit ? {1'b0, weight} : 3'd0);
    if (sum >= 3'd3) sum = sum - 3'd3;
  end

  always_ff @(posedge CLK) begin
    if (!CLR)        residue <= 2'd0;
    else if (clear)  residue <= 2'd0;
    else if (enable) residue <= sum[1:0];
  end

endmodule

// File: rtl/booth_residue_checker.sv
// rtl/booth_residue_checker.sv - mod-3 residue check of the 13x13 signed Booth multiplier product
module booth_residue_checker
  import booth_chk_pkg::*;
#(
  parameter int TIMEOUT_CYC = 63,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 START,
  input  logic [OP_W-1:0]      MULTIPLIER,
  input  logic [OP_W-1:0]      MULTIPLICAND,
  input  logic [RES_W-1:0]     RESULT,
  input  logic                 DONE,
  output logic                 BUSY,
  output logic                 CHK_VALID,
  output logic                 CHK_ERR,
  output logic                 TIMEOUT,
  output logic [1:0]           RES_PROD,
  output logic [1:0]           RES_EXP,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);

  chk_state_t           state, state_next;
  logic [OP_W-1:0]      op_a_q, op_b_q;
  logic [RES_W-1:0]     prod_q;
  logic [4:0]           bit_cnt;
  logic [TIMER_W-1:0]   timer;
  logic                 armed, timeout_q;
  logic [1:0]           res_prod_q, res_exp_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [1:0]           acc_a, acc_b, acc_p, exp_now;
  logic                 start_ok, capture, timeout_hit, op_en, chk_err;

  always_comb begin
    state_next  = state;
    start_ok    = 1'b0;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: if (START) begin
        start_ok   = 1'b1;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        // a stale DONE from the previous operation is ignored until it has dropped once
        if (armed && DONE) begin
          capture    = 1'b1;
          state_next = CHECK;
        end else if (timer == TIMER_W'(TIMEOUT_CYC - 1)) begin
          timeout_hit = 1'b1;
          state_next  = REPORT;
        end
      end
      CHECK:   if (bit_cnt == 5'(RES_W - 1)) state_next = REPORT;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign op_en   = (state == CHECK) && (bit_cnt < 5'(OP_W));
  assign exp_now = mod3_mul(acc_a, acc_b);
  assign chk_err = (state == REPORT) && (timeout_q || (acc_p != exp_now));

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state      <= IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      prod_q     <= '0;
      bit_cnt    <= '0;
      timer      <= '0;
      armed      <= 1'b0;
      timeout_q  <= 1'b0;
      res_prod_q <= '0;
      res_exp_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state <= state_next;
      if (start_ok) begin
        op_a_q    <= MULTIPLIER;
        op_b_q    <= MULTIPLICAND;
        timer     <= '0;
        armed     <= 1'b0;
        timeout_q <= 1'b0;
      end
      if (state == WAIT_DONE) begin
        timer <= timer + 1'b1;
        if (!DONE) armed <= 1'b1;
      end
      if (timeout_hit) timeout_q <= 1'b1;
      if (capture) begin
        prod_q  <= RESULT;
        bit_cnt <= '0;
      end
      // operands and product are shifted so bit k always sits at position 0
      if (state == CHECK) begin
        bit_cnt <= bit_cnt + 1'b1;
        prod_q  <= prod_q >> 1;
        op_a_q  <= op_a_q >> 1;
        op_b_q  <= op_b_q >> 1;
      end
      if ((state == REPORT) && !timeout_q) begin
        res_prod_q <= acc_p;
        res_exp_q  <= exp_now;
      end
      if (chk_err && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  mod3_serial_acc u_acc_a (
    .CLK(CLK), .CLR(CLR), .clear(start_ok), .enable(op_en),
    .data_bit(op_a_q[0]), .weight(mod3_weight(bit_cnt, 5'(OP_W - 1))), .residue(acc_a)
  );

  mod3_serial_acc u_acc_b (
    .CLK(CLK), .CLR(CLR), .clear(start_ok), .enable(op_en),
    .data_bit(op_b_q[0]), .weight(mod3_weight(bit_cnt, 5'(OP_W - 1))), .residue(acc_b)
  );

  mod3_serial_acc u_acc_p (
    .CLK(CLK), .CLR(CLR), .clear(start_ok), .enable(state == CHECK),
    .data_bit(prod_q[0]), .weight(mod3_weight(bit_cnt, 5'(RES_W - 1))), .residue(acc_p)
  );

  // a timed-out operation leaves the previously reported residues on display
  assign BUSY      = (state != IDLE);
  assign CHK_VALID = (state == REPORT);
  assign CHK_ERR   = chk_err;
  assign TIMEOUT   = (state == REPORT) && timeout_q;
  assign RES_PROD  = ((state == REPORT) && !timeout_q) ? acc_p   : res_prod_q;
  assign RES_EXP   = ((state == REPORT) && !timeout_q) ? exp_now : res_exp_q;
  assign ERR_CNT   = err_cnt_q;

endmodule

// File: tb/tb_booth_residue_checker.sv
// tb/tb_booth_residue_checker.sv - self-checking bench for booth_residue_checker
module tb_booth_residue_checker;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        START = 1'b0;
  logic        DONE = 1'b0;
  logic [12:0] MULTIPLIER = '0;
  logic [12:0] MULTIPLICAND = '0;
  logic [25:0] RESULT = '0;

  logic       busy, chk_valid, chk_err, timeout;
  logic [1:0] res_prod, res_exp;
  logic [7:0] err_cnt;
  logic       busy_s, chk_valid_s, chk_err_s, timeout_s;
  logic [1:0] res_prod_s, res_exp_s;
  logic [1:0] err_cnt_s;

  int vectors = 0;
  int miscompares = 0;
  int fails = 0;
  int held_prod = 0;
  int held_exp = 0;

  booth_residue_checker dut (
    .CLK(CLK), .CLR(CLR), .START(START), .MULTIPLIER(MULTIPLIER), .MULTIPLICAND(MULTIPLICAND),
    .RESULT(RESULT), .DONE(DONE), .BUSY(busy), .CHK_VALID(chk_valid), .CHK_ERR(chk_err),
    .TIMEOUT(timeout), .RES_PROD(res_prod), .RES_EXP(res_exp), .ERR_CNT(err_cnt)
  );

  booth_residue_checker #(.ERR_CNT_W(2)) dut_sat (
    .CLK(CLK), .CLR(CLR), .START(START), .MULTIPLIER(MULTIPLIER), .MULTIPLICAND(MULTIPLICAND),
    .RESULT(RESULT), .DONE(DONE), .BUSY(busy_s), .CHK_VALID(chk_valid_s), .CHK_ERR(chk_err_s),
    .TIMEOUT(timeout_s), .RES_PROD(res_prod_s), .RES_EXP(res_exp_s), .ERR_CNT(err_cnt_s)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int res3(input longint v);
    int r;
    r = int'(v % 3);
    if (r < 0) r += 3;
    return r;
  endfunction

  function automatic int sat(input int n, input int m);
    return (n > m) ? m : n;
  endfunction

  task automatic check_counts();
    check("err_cnt", err_cnt, sat(fails, 255));
    check("err_cnt_sat", err_cnt_s, sat(fails, 3));
  endtask

  task automatic run_op(input logic [12:0] a, input logic [12:0] b, input logic [25:0] r,
                        input int delay, input bit stale, input bit poke);
    int n, rp, ex;
    bit bad;
    rp  = res3($signed(r));
    ex  = (res3($signed(a)) * res3($signed(b))) % 3;
    bad = (rp != ex);
    @(negedge CLK);
    MULTIPLIER = a; MULTIPLICAND = b; START = 1'b1; DONE = stale;
    if (stale) RESULT = r ^ 26'h1;
    @(negedge CLK);
    START = 1'b0;
    check("busy_after_start", busy, 1);
    if (poke) begin
      MULTIPLIER = ~a; MULTIPLICAND = a ^ b ^ 13'h05A5; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
    end
    if (stale) begin
      repeat (2) @(negedge CLK);
      DONE = 1'b0;
      repeat (3) @(negedge CLK);
    end else begin
      DONE = 1'b0;
      repeat (delay) @(negedge CLK);
    end
    RESULT = r; DONE = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    DONE = 1'b0; RESULT = r ^ 26'h3;
    n = 1;
    while (!chk_valid && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check("latency", n, 27);
    check("chk_err", chk_err, bad);
    check("timeout_strobe", timeout, 0);
    check("res_prod", res_prod, rp);
    check("res_exp", res_exp, ex);
    if (bad) fails++;
    held_prod = rp; held_exp = ex;
    START = 1'b1; MULTIPLIER = a + 13'd1;
    @(negedge CLK);
    START = 1'b0;
    check("busy_after_report", busy, 0);
    check("valid_drop", chk_valid, 0);
    check("res_prod_hold", res_prod, rp);
    check_counts();
  endtask

  task automatic run_timeout();
    int n;
    @(negedge CLK);
    MULTIPLIER = 13'($urandom); MULTIPLICAND = 13'($urandom); START = 1'b1; DONE = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    n = 1;
    while (!chk_valid && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("timeout_latency", n, 64);
    check("timeout_flag", timeout, 1);
    check("timeout_err", chk_err, 1);
    check("timeout_prod_hold", res_prod, held_prod);
    check("timeout_exp_hold", res_exp, held_exp);
    fails++;
    @(negedge CLK);
    check("timeout_idle", busy, 0);
    check_counts();
  endtask

  initial begin
    logic signed [25:0] p;
    logic [12:0] ra, rb;
    int n, seen;

    repeat (3) @(negedge CLK);
    check("rst_busy", busy, 0);
    check("rst_valid", chk_valid, 0);
    check("rst_err", chk_err, 0);
    check("rst_timeout", timeout, 0);
    check("rst_res_prod", res_prod, 0);
    check("rst_res_exp", res_exp, 0);
    check_counts();
    CLR = 1'b1;

    run_op(13'd3, 13'd5, 26'd15, 27, 1'b0, 1'b0);
    run_op(13'h1FFF, 13'h1FFF, 26'h0000001, 5, 1'b0, 1'b1);
    run_op(13'd3, 13'd5, 26'd16, 4, 1'b0, 1'b0);
    run_op(13'd7, 13'h1FF0, 26'h3FFFF90, 0, 1'b1, 1'b0);
    run_timeout();

    for (int i = 0; i < 12; i++) begin
      ra = 13'($urandom);
      rb = 13'($urandom);
      p  = $signed(ra) * $signed(rb);
      if ($urandom_range(0, 1) == 1) p = p ^ (26'd1 << $urandom_range(0, 25));
      run_op(ra, rb, p, $urandom_range(1, 30), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    @(negedge CLK);
    MULTIPLIER = 13'd3; MULTIPLICAND = 13'd5; START = 1'b1; DONE = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    RESULT = 26'd16; DONE = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    DONE = 1'b0;
    repeat (10) @(negedge CLK);
    CLR = 1'b0;
    @(negedge CLK);
    fails = 0; held_prod = 0; held_exp = 0;
    check("midcheck_busy", busy, 0);
    check("midcheck_valid", chk_valid, 0);
    check("midcheck_res_prod", res_prod, 0);
    check_counts();
    CLR = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (chk_valid || chk_valid_s) seen++;
    end
    check("midcheck_no_verdict", seen, 0);

    for (int i = 0; i < 4; i++) run_op(13'd3, 13'd5, 26'd16, 2, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
